riscv_lsu_dmem: RTL and testbench

Load-store unit serving the EX stage. It drives the data-memory request/grant/rvalid interface and reports lsu_ready_ex_o to EX. It returns aligned, sign- or zero-extended load data to WB together with lsu_ready_wb_o. Misaligned accesses are split into two bus transactions, with the ID stage re-issuing the second half.

---
 rtl/riscv_lsu_dmem.sv | 115 +++++++++++
 tb/tb_riscv_lsu_dmem.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_dmem.sv
// riscv_lsu_dmem: load-store unit between EX/WB and the req/gnt/rvalid data bus; splits misaligned accesses.
// Define LSU_DIFT_TAG_EN to carry a one-bit taint tag alongside store and load data.
module riscv_lsu_dmem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_req_ex_i,
  input  logic              data_we_ex_i,
  input  logic [1:0]        data_type_ex_i,
  input  logic              data_sign_ext_ex_i,
  input  logic [ADDR_W-1:0] data_addr_ex_i,
  input  logic [DATA_W-1:0] data_wdata_ex_i,
  input  logic              data_misaligned_ex_i,
  input  logic              ex_valid_i,
  output logic              data_misaligned_o,
  output logic              lsu_ready_ex_o,
  output logic              lsu_ready_wb_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic [DATA_W-1:0] data_rdata_i
`ifdef LSU_DIFT_TAG_EN
  ,
  input  logic              data_wdata_tag_ex_i,
  output logic              data_wtag_o,
  input  logic              data_rtag_i,
  output logic              lsu_rdata_tag_o
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT_RVALID, WAIT_RVALID_EX_STALL, IDLE_EX_STALL} state_t;
  state_t state;
  logic [1:0] off, type_q, off_q;
  logic is_word, is_half, split, gnt, outstanding, rv, ld_done;
  logic we_q, sign_q, mis_q, first_q;
  logic [3:0] be_base;
  logic [7:0] be_wide;
  logic [2*DATA_W-1:0] src;
  logic [DATA_W-1:0] rdata_q, shifted, ext;

  assign off = data_addr_ex_i[1:0];
  assign is_word = data_type_ex_i == 2'b00;
  assign is_half = data_type_ex_i == 2'b01;
  assign split = (is_word && off != 2'd0) || (is_half && off == 2'd3);
  assign gnt = data_req_o & data_gnt_i;
  assign outstanding = state == WAIT_RVALID || state == WAIT_RVALID_EX_STALL;
  assign rv = data_rvalid_i & outstanding;

  // a new request may only overlap the response of the previous one
  assign data_req_o = data_req_ex_i && (state == IDLE || (state == WAIT_RVALID && data_rvalid_i));
  assign lsu_ready_ex_o = (state == IDLE || state == WAIT_RVALID) ?
                          (state == IDLE || data_rvalid_i) && (!data_req_ex_i || data_gnt_i) : 1'b1;
  assign lsu_ready_wb_o = outstanding ? data_rvalid_i : 1'b1;
  assign data_misaligned_o = gnt & split & !data_misaligned_ex_i;

  assign data_addr_o = {data_addr_ex_i[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, data_misaligned_ex_i}, 2'b00};
  assign be_base = is_word ? 4'b1111 : is_half ? 4'b0011 : 4'b0001;
  assign be_wide = {4'b0000, be_base} << off;
  assign data_be_o = !data_req_o ? 4'b0000 : data_misaligned_ex_i ? be_wide[7:4] : be_wide[3:0];
  assign data_we_o = data_req_o & data_we_ex_i;
  assign data_wdata_o = DATA_W'({data_wdata_ex_i, data_wdata_ex_i} >> (6'd32 - {1'b0, off, 3'b000}));

  // second half merges fresh low bytes above the bytes kept from the first half
  assign src = mis_q ? {data_rdata_i, rdata_q} : {{DATA_W{1'b0}}, data_rdata_i};
  assign shifted = DATA_W'(src >> {off_q, 3'b000});
  assign ext = type_q[1] ? {{24{sign_q & shifted[7]}}, shifted[7:0]} :
               type_q[0] ? {{16{sign_q & shifted[15]}}, shifted[15:0]} : shifted;
  assign ld_done = rv & !we_q & !first_q;
  assign lsu_rdata_o = ld_done ? ext : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      off_q   <= 2'b00;
      sign_q  <= 1'b0;
      mis_q   <= 1'b0;
      first_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (gnt) begin
        we_q    <= data_we_ex_i;
        type_q  <= data_type_ex_i;
        off_q   <= off;
        sign_q  <= data_sign_ext_ex_i;
        mis_q   <= data_misaligned_ex_i;
        first_q <= split & !data_misaligned_ex_i;
      end
      if (rv && !we_q && first_q) rdata_q <= data_rdata_i;
      case (state)
        IDLE:                 if (gnt) state <= ex_valid_i ? WAIT_RVALID : WAIT_RVALID_EX_STALL;
        WAIT_RVALID:          if (data_rvalid_i) state <= !gnt ? IDLE : ex_valid_i ? WAIT_RVALID : WAIT_RVALID_EX_STALL;
        WAIT_RVALID_EX_STALL: if (data_rvalid_i) state <= ex_valid_i ? IDLE : IDLE_EX_STALL;
        default:              if (ex_valid_i) state <= IDLE;
      endcase
    end
  end

`ifdef LSU_DIFT_TAG_EN
  logic rtag_q;
  assign data_wtag_o = data_wdata_tag_ex_i;
  assign lsu_rdata_tag_o = ld_done & (data_rtag_i | (mis_q & rtag_q));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rtag_q <= 1'b0;
    else if (rv && !we_q && first_q) rtag_q <= data_rtag_i;
  end
`endif
endmodule

// File: tb/tb_riscv_lsu_dmem.sv
// tb_riscv_lsu_dmem: randomized bench for riscv_lsu_dmem; bench plays EX/ID and the memory,
// checking against a byte-addressed reference memory.
module tb_riscv_lsu_dmem;
  logic clk = 1'b0, rst_n = 1'b0;
  logic data_req_ex_i, data_we_ex_i, data_sign_ext_ex_i, data_misaligned_ex_i, ex_valid_i;
  logic [1:0] data_type_ex_i;
  logic [31:0] data_addr_ex_i, data_wdata_ex_i, data_rdata_i;
  logic data_gnt_i, data_rvalid_i;
  logic data_misaligned_o, lsu_ready_ex_o, lsu_ready_wb_o, data_req_o, data_we_o;
  logic [31:0] lsu_rdata_o, data_addr_o, data_wdata_o;
  logic [3:0] data_be_o;
  int total = 0, bad = 0;
  logic [7:0] mmem [256];
  logic [7:0] bmem [256];
  logic [3:0] last_be;
  logic [31:0] last_wd, last_rd;

  riscv_lsu_dmem dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_ex_i(data_req_ex_i), .data_we_ex_i(data_we_ex_i), .data_type_ex_i(data_type_ex_i),
    .data_sign_ext_ex_i(data_sign_ext_ex_i), .data_addr_ex_i(data_addr_ex_i),
    .data_wdata_ex_i(data_wdata_ex_i), .data_misaligned_ex_i(data_misaligned_ex_i),
    .ex_valid_i(ex_valid_i), .data_misaligned_o(data_misaligned_o),
    .lsu_ready_ex_o(lsu_ready_ex_o), .lsu_ready_wb_o(lsu_ready_wb_o), .lsu_rdata_o(lsu_rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] ty);
    return ty == 2'd0 ? 4 : ty == 2'd1 ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_ld(input logic [31:0] a, input logic [1:0] ty, input logic sg);
    int n;
    logic [31:0] v;
    n = nb(ty);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mmem[8'(a + 32'(i))]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] bus_word(input logic [31:0] w);
    return {bmem[8'(w + 32'd3)], bmem[8'(w + 32'd2)], bmem[8'(w + 32'd1)], bmem[8'(w)]};
  endfunction

  task automatic poke_w(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      mmem[8'(a + 32'(i))] = v[8*i +: 8];
      bmem[8'(a + 32'(i))] = v[8*i +: 8];
    end
  endtask

  // one bus transaction: gd wait cycles before grant, rd cycles before rvalid
  task automatic access(input logic we, input logic [1:0] ty, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic mx, input int gd, input int rd,
                        input logic exg, input logic exr);
    int n, off, k;
    logic mis;
    logic [31:0] ea, ewd, d, wa, er;
    logic [3:0] ebe;
    n = nb(ty);
    off = int'(a[1:0]);
    mis = off + n > 4;
    ea = ((a >> 2) + 32'(mx)) << 2;
    for (int l = 0; l < 4; l++) begin
      d = ea + 32'(l) - a;
      ebe[l] = d < 32'(n);
      k = (l - off) & 3;
      ewd[8*l +: 8] = wd[8*k +: 8];
    end
    er = (we || (mis && !mx)) ? 32'h0 : model_ld(a, ty, sg);
    @(negedge clk);
    data_req_ex_i = 1'b1; data_we_ex_i = we; data_type_ex_i = ty; data_sign_ext_ex_i = sg;
    data_addr_ex_i = a; data_wdata_ex_i = wd; data_misaligned_ex_i = mx;
    ex_valid_i = 1'b0; data_gnt_i = 1'b0;
    for (int i = 0; i < gd; i++) begin
      #1;
      chk("wait_req", data_req_o, 1);
      chk("wait_addr", data_addr_o, ea);
      chk("wait_be", data_be_o, ebe);
      chk("wait_wdata", data_wdata_o, ewd);
      chk("wait_rdy_ex", lsu_ready_ex_o, 0);
      @(negedge clk);
    end
    data_gnt_i = 1'b1; ex_valid_i = exg;
    #1;
    chk("gnt_req", data_req_o, 1);
    chk("gnt_addr", data_addr_o, ea);
    chk("gnt_be", data_be_o, ebe);
    chk("gnt_we", data_we_o, we);
    chk("gnt_wdata", data_wdata_o, ewd);
    chk("gnt_mis", data_misaligned_o, mis && !mx);
    chk("gnt_rdy_ex", lsu_ready_ex_o, 1);
    last_be = data_be_o;
    last_wd = data_wdata_o;
    wa = data_addr_o;
    if (we) for (int l = 0; l < 4; l++) if (data_be_o[l]) bmem[8'(wa + 32'(l))] = data_wdata_o[8*l +: 8];
    @(negedge clk);
    data_req_ex_i = 1'b0; data_gnt_i = 1'b0; ex_valid_i = 1'b0;
    for (int i = 0; i < rd; i++) begin
      #1;
      chk("pend_rdy_wb", lsu_ready_wb_o, 0);
      chk("pend_req", data_req_o, 0);
      if (exg) chk("pend_rdy_ex", lsu_ready_ex_o, 0);
      @(negedge clk);
    end
    data_rvalid_i = 1'b1; data_rdata_i = bus_word(wa); ex_valid_i = exr;
    #1;
    chk("rv_rdy_wb", lsu_ready_wb_o, 1);
    chk("rv_rdata", lsu_rdata_o, er);
    chk("rv_req", data_req_o, 0);
    last_rd = lsu_rdata_o;
    @(negedge clk);
    data_rvalid_i = 1'b0; data_rdata_i = $urandom; ex_valid_i = 1'b0;
    if (!exg && !exr) begin
      data_req_ex_i = 1'b1;
      #1;
      chk("stall_req", data_req_o, 0);
      chk("stall_rdy_ex", lsu_ready_ex_o, 1);
      @(negedge clk);
      ex_valid_i = 1'b1;
      @(negedge clk);
      #1;
      chk("resume_req", data_req_o, 1);
      data_req_ex_i = 1'b0; ex_valid_i = 1'b0;
    end
  endtask

  task automatic op(input logic we, input logic [1:0] ty, input logic sg, input logic [31:0] a,
                    input logic [31:0] wd, input int gd, input int rd, input logic exg, input logic exr);
    access(we, ty, sg, a, wd, 1'b0, gd, rd, exg, exr);
    if (int'(a[1:0]) + nb(ty) > 4) access(we, ty, sg, a, wd, 1'b1, rd, gd, exr, exg);
    if (we) for (int i = 0; i < nb(ty); i++) mmem[8'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  initial begin
    data_req_ex_i = 0; data_we_ex_i = 0; data_type_ex_i = 0; data_sign_ext_ex_i = 0;
    data_addr_ex_i = 0; data_wdata_ex_i = 0; data_misaligned_ex_i = 0; ex_valid_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    for (int i = 0; i < 256; i++) begin
      mmem[i] = 8'($urandom);
      bmem[i] = mmem[i];
    end
    #1;
    chk("rst_req", data_req_o, 0);
    chk("rst_rdy_ex", lsu_ready_ex_o, 1);
    chk("rst_rdy_wb", lsu_ready_wb_o, 1);
    chk("rst_rdata", lsu_rdata_o, 0);
    chk("rst_mis", data_misaligned_o, 0);
    chk("rst_be", data_be_o, 0);
    chk("rst_we", data_we_o, 0);
    chk("rst_addr", data_addr_o, 0);
    chk("rst_wdata", data_wdata_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    poke_w(32'h100, 32'hDEAD_BEEF);
    op(0, 2'd0, 0, 32'h100, 0, 0, 0, 1, 1);
    chk("tp_word_be", last_be, 4'b1111);
    chk("tp_word_rdata", last_rd, 32'hDEAD_BEEF);
    poke_w(32'h100, 32'h80FF_FFFF);
    op(0, 2'd2, 1, 32'h103, 0, 0, 0, 1, 1);
    chk("tp_sb_be", last_be, 4'b1000);
    chk("tp_sb_rdata", last_rd, 32'hFFFF_FF80);
    op(0, 2'd2, 0, 32'h103, 0, 1, 1, 1, 1);
    chk("tp_ub_rdata", last_rd, 32'h0000_0080);
    op(1, 2'd1, 0, 32'h102, 32'h0000_ABCD, 0, 0, 1, 1);
    chk("tp_sh_be", last_be, 4'b1100);
    chk("tp_sh_wdata", last_wd, 32'hABCD_0000);
    poke_w(32'h200, 32'h3344_5566);
    poke_w(32'h204, 32'h7788_1122);
    op(0, 2'd0, 0, 32'h202, 0, 0, 0, 1, 1);
    chk("tp_mis_be2", last_be, 4'b0011);
    chk("tp_mis_rdata", last_rd, 32'h1122_3344);
    op(0, 2'd0, 0, 32'h300, 0, 3, 1, 0, 0);
    op(0, 2'd0, 1, 32'hFFFF_FFFE, 0, 1, 0, 1, 0);
    op(1, 2'd1, 0, 32'hFFFF_FFFF, 32'h0000_5AA5, 0, 1, 0, 1);
    op(0, 2'd1, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 1);
    chk("wrap_half", last_rd, 32'h0000_5AA5);

    // back-to-back: second request granted in the cycle the first response arrives
    @(negedge clk);
    data_req_ex_i = 1; data_we_ex_i = 0; data_type_ex_i = 2'd0; data_sign_ext_ex_i = 0;
    data_addr_ex_i = 32'h40; data_misaligned_ex_i = 0; data_gnt_i = 1; ex_valid_i = 1;
    #1 chk("b2b_gnt_a", lsu_ready_ex_o, 1);
    @(negedge clk);
    data_type_ex_i = 2'd1; data_sign_ext_ex_i = 1; data_addr_ex_i = 32'h46; data_gnt_i = 0; ex_valid_i = 0;
    #1;
    chk("b2b_hold_req", data_req_o, 0);
    chk("b2b_hold_rdy", lsu_ready_ex_o, 0);
    @(negedge clk);
    data_rvalid_i = 1; data_rdata_i = bus_word(32'h40); data_gnt_i = 1; ex_valid_i = 1;
    #1;
    chk("b2b_req", data_req_o, 1);
    chk("b2b_addr", data_addr_o, 32'h44);
    chk("b2b_rdy_ex", lsu_ready_ex_o, 1);
    chk("b2b_rdata_a", lsu_rdata_o, model_ld(32'h40, 2'd0, 1'b0));
    @(negedge clk);
    data_rdata_i = bus_word(32'h44); data_req_ex_i = 0; data_gnt_i = 0; ex_valid_i = 0;
    #1;
    chk("b2b_rdy_wb", lsu_ready_wb_o, 1);
    chk("b2b_rdata_b", lsu_rdata_o, model_ld(32'h46, 2'd1, 1'b1));
    @(negedge clk);
    data_rvalid_i = 0;

    // reset while a load is outstanding, then a stray response
    @(negedge clk);
    data_req_ex_i = 1; data_type_ex_i = 2'd0; data_addr_ex_i = 32'h80; data_gnt_i = 1; ex_valid_i = 1;
    @(negedge clk);
    data_req_ex_i = 0; data_gnt_i = 0; ex_valid_i = 0;
    #1 chk("pre_rst_rdy_wb", lsu_ready_wb_o, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", data_req_o, 0);
    chk("mid_rst_rdy_ex", lsu_ready_ex_o, 1);
    chk("mid_rst_rdy_wb", lsu_ready_wb_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data_rvalid_i = 1; data_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("stray_rdy_wb", lsu_ready_wb_o, 1);
    chk("stray_rdata", lsu_rdata_o, 0);
    @(negedge clk);
    data_rvalid_i = 0;

    for (int t = 0; t < 200; t++)
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, $urandom,
         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      a = $urandom;
      op(0, 2'd0, 0, a, 0, 0, 0, 1, 1);
      chk("rand_word_readback", last_rd, model_ld(a, 2'd0, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
